// File: rtl/md5_hit_reporter.sv
// md5_hit_reporter: aligns MD5 pipeline hits with their guess and reports the plaintext (or a miss) over UART 8N1.
module md5_hit_reporter #(
    parameter int PIPE_LATENCY = 64,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [127:0] guess,
    input  logic         guess_valid,
    input  logic [3:0]   guesslen,
    input  logic         gen_done,
    input  logic         hit,
    output logic         uart_tx,
    output logic         busy,
    output logic         found,
    output logic         finished
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CMAX = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_BODY, S_TERM, S_DONE} seq_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_t;

    logic [127:0] gp [PIPE_LATENCY];
    logic         vp [PIPE_LATENCY];
    logic         dp [PIPE_LATENCY];
    logic [127:0] guess_d, cap_guess;
    logic         valid_d, done_d, qhit, mode_hit, bit_end, byte_end;
    logic [3:0]   cap_len, bidx, nxt_idx;
    logic [7:0]   sh, tx_byte;
    logic [2:0]   nbit;
    logic [CW-1:0] cnt;
    seq_t         st, nxt_st;
    tx_t          ts;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PIPE_LATENCY; i++) begin
                gp[i] <= '0;
                vp[i] <= 1'b0;
                dp[i] <= 1'b0;
            end
        end else begin
            gp[0] <= guess;
            vp[0] <= guess_valid;
            dp[0] <= gen_done;
            for (int i = 1; i < PIPE_LATENCY; i++) begin
                gp[i] <= gp[i-1];
                vp[i] <= vp[i-1];
                dp[i] <= dp[i-1];
            end
        end
    end

    // Next byte is chosen from the state the sequencer is about to enter, so bytes run back-to-back.
    always_comb begin
        guess_d  = gp[PIPE_LATENCY-1];
        valid_d  = vp[PIPE_LATENCY-1];
        done_d   = dp[PIPE_LATENCY-1];
        qhit     = hit & valid_d;
        bit_end  = cnt == CMAX;
        byte_end = ts == TX_STOP && bit_end;
        nxt_st   = !byte_end ? st :
                   st == S_HDR ? (mode_hit && cap_len != 4'd0 ? S_BODY : S_TERM) :
                   st == S_BODY && bidx != cap_len - 4'd1 ? S_BODY :
                   st == S_BODY ? S_TERM : S_DONE;
        nxt_idx  = byte_end && st == S_BODY ? bidx + 4'd1 : bidx;
        tx_byte  = nxt_st == S_HDR ? (mode_hit ? 8'h48 : 8'h4E) :
                   nxt_st == S_BODY ? cap_guess[{nxt_idx, 3'b000} +: 8] : 8'h0A;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st        <= S_IDLE;
            ts        <= TX_IDLE;
            cnt       <= '0;
            nbit      <= '0;
            sh        <= '0;
            bidx      <= '0;
            cap_guess <= '0;
            cap_len   <= '0;
            mode_hit  <= 1'b0;
            uart_tx   <= 1'b1;
            busy      <= 1'b0;
            found     <= 1'b0;
            finished  <= 1'b0;
        end else begin
            if (st == S_IDLE && qhit) begin
                cap_guess <= guess_d;
                cap_len   <= guesslen;
                found     <= 1'b1;
                mode_hit  <= 1'b1;
                st        <= S_HDR;
            end else if (st == S_IDLE && done_d) begin
                mode_hit <= 1'b0;
                st       <= S_HDR;
            end
            cnt <= ts == TX_IDLE || bit_end ? '0 : cnt + 1'b1;
            case (ts)
                TX_IDLE: if (st == S_HDR) begin
                    sh      <= tx_byte;
                    uart_tx <= 1'b0;
                    busy    <= 1'b1;
                    ts      <= TX_START;
                end
                TX_START: if (bit_end) begin
                    uart_tx <= sh[0];
                    sh      <= sh >> 1;
                    nbit    <= '0;
                    ts      <= TX_DATA;
                end
                TX_DATA: if (bit_end) begin
                    uart_tx <= nbit == 3'd7 ? 1'b1 : sh[0];
                    sh      <= sh >> 1;
                    nbit    <= nbit + 3'd1;
                    ts      <= nbit == 3'd7 ? TX_STOP : TX_DATA;
                end
                TX_STOP: if (bit_end) begin
                    st   <= nxt_st;
                    bidx <= nxt_idx;
                    if (nxt_st == S_DONE) begin
                        ts       <= TX_IDLE;
                        busy     <= 1'b0;
                        finished <= 1'b1;
                    end else begin
                        sh      <= tx_byte;
                        uart_tx <= 1'b0;
                        ts      <= TX_START;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_md5_hit_reporter.sv
// tb_md5_hit_reporter: directed and randomized frames checked against a cycle-history reference model.
module tb_md5_hit_reporter;
    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] guess;
    logic         guess_valid, gen_done, hit;
    logic [3:0]   guesslen;
    logic         uart_tx, busy, found, finished;

    int vectors = 0;
    int miscompares = 0;
    logic [127:0] hist_g [64];
    logic         hist_v [64];
    logic         hist_h [64];
    logic         hist_d [64];
    logic [7:0]   exp_q [$];
    logic         exp_found;

    md5_hit_reporter #(.PIPE_LATENCY(4), .CLKS_PER_BIT(4)) dut (
        .clk(clk), .reset(reset), .guess(guess), .guess_valid(guess_valid),
        .guesslen(guesslen), .gen_done(gen_done), .hit(hit),
        .uart_tx(uart_tx), .busy(busy), .found(found), .finished(finished)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        guess = '0;
        guess_valid = 1'b0;
        hit = 1'b0;
        gen_done = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic fill(input logic allv);
        for (int c = 0; c < 64; c++) begin
            hist_g[c] = {$urandom, $urandom, $urandom, $urandom};
            hist_v[c] = allv ? 1'b1 : 1'($urandom_range(0, 1));
            hist_h[c] = 1'b0;
            hist_d[c] = 1'b0;
        end
    endtask

    task automatic drive_to(input int last, input logic hold_hit);
        for (int c = 0; c <= last; c++) begin
            guess = hist_g[c];
            guess_valid = hist_v[c];
            hit = hist_h[c];
            gen_done = hist_d[c];
            @(posedge clk);
            #1;
        end
        guess = {$urandom, $urandom, $urandom, $urandom};
        guess_valid = 1'b1;
        hit = hold_hit;
        gen_done = hist_d[last];
    endtask

    // First cycle where a valid hit or a delayed done is seen decides the frame; hit takes priority.
    task automatic build_expect(input int last, input logic [3:0] len);
        exp_q.delete();
        exp_found = 1'b0;
        for (int c = 4; c <= last; c++) begin
            if (hist_h[c] && hist_v[c-4]) begin
                exp_q.push_back(8'h48);
                for (int i = 0; i < int'(len); i++) exp_q.push_back(hist_g[c-4][8*i +: 8]);
                exp_q.push_back(8'h0A);
                exp_found = 1'b1;
                return;
            end else if (hist_d[c-4]) begin
                exp_q.push_back(8'h4E);
                exp_q.push_back(8'h0A);
                return;
            end
        end
    endtask

    task automatic recv(input string tag);
        int w, bc, nb;
        logic [9:0] sh;
        w = 0;
        bc = 0;
        nb = exp_q.size();
        sh = '0;
        while (uart_tx !== 1'b0 && w < 300) begin
            @(posedge clk);
            #1 w++;
        end
        chk({tag, " start_latency"}, 128'(w <= 2), 128'(1));
        if (w >= 300) return;
        chk({tag, " found"}, 128'(found), 128'(exp_found));
        for (int t = 0; t < 40 * nb; t++) begin
            if (t % 4 == 2) sh = {uart_tx, sh[9:1]};
            if (t % 40 == 38) chk($sformatf("%s byte%0d", tag, t / 40), 128'(sh), 128'({1'b1, exp_q[t/40], 1'b0}));
            bc += int'(busy);
            @(posedge clk);
            #1;
        end
        chk({tag, " busy_cycles"}, 128'(bc), 128'(40 * nb));
        chk({tag, " busy_end"}, 128'(busy), 128'(0));
        chk({tag, " finished"}, 128'(finished), 128'(1));
        repeat (8) @(posedge clk);
        #1 chk({tag, " idle_after"}, 128'({uart_tx, busy, finished}), 128'(3'b101));
    endtask

    initial begin
        int hc, hc2;
        guesslen = 4'd0;
        do_reset();
        chk("reset uart_tx", 128'(uart_tx), 128'(1));
        chk("reset busy", 128'(busy), 128'(0));
        chk("reset found", 128'(found), 128'(0));
        chk("reset finished", 128'(finished), 128'(0));

        do_reset(); fill(1'b1);
        hist_g[0] = 128'h636261;
        guesslen = 4'd3;
        hist_h[4] = 1'b1;
        drive_to(4, 1'b0); build_expect(4, guesslen); recv("abc");

        do_reset(); fill(1'b1);
        guesslen = 4'd8;
        hist_h[10] = 1'b1;
        drive_to(10, 1'b0); build_expect(10, guesslen); recv("align");

        do_reset(); fill(1'b1);
        guesslen = 4'd5;
        for (int c = 20; c < 64; c++) hist_d[c] = 1'b1;
        drive_to(24, 1'b0); build_expect(24, guesslen); recv("miss");

        do_reset(); fill(1'b1);
        guesslen = 4'd6;
        hist_h[12] = 1'b1;
        for (int c = 8; c < 64; c++) hist_d[c] = 1'b1;
        drive_to(12, 1'b1); build_expect(12, guesslen); recv("hit_vs_done");

        do_reset(); fill(1'b0);
        guesslen = 4'd4;
        hist_v[5] = 1'b0; hist_h[9] = 1'b1;
        hist_v[7] = 1'b1; hist_h[11] = 1'b1;
        drive_to(11, 1'b0); build_expect(11, guesslen); recv("invalid_hit");

        do_reset(); fill(1'b1);
        guesslen = 4'd0;
        hist_h[6] = 1'b1;
        drive_to(6, 1'b0); build_expect(6, guesslen); recv("len0");

        do_reset(); fill(1'b1);
        guesslen = 4'd15;
        hist_h[7] = 1'b1;
        drive_to(7, 1'b0); build_expect(7, guesslen); recv("len15");

        do_reset(); fill(1'b1);
        guesslen = 4'd4;
        hist_h[5] = 1'b1;
        drive_to(5, 1'b0);
        repeat (50) @(posedge clk);
        #1 hc = 0;
        while (uart_tx !== 1'b0 && hc < 40) begin
            @(posedge clk);
            #1 hc++;
        end
        chk("midreset pre", 128'({uart_tx, busy}), 128'(2'b01));
        #2 reset = 1'b1;
        #1 chk("midreset uart_tx", 128'(uart_tx), 128'(1));
        chk("midreset flags", 128'({busy, found, finished}), 128'(0));
        @(posedge clk);
        #1 reset = 1'b0;
        fill(1'b1);
        guesslen = 4'($urandom_range(0, 15));
        hist_h[9] = 1'b1;
        drive_to(9, 1'b0); build_expect(9, guesslen); recv("after_reset");

        repeat (4) begin
            do_reset(); fill(1'b0);
            guesslen = 4'($urandom_range(0, 15));
            hc = $urandom_range(5, 30);
            hc2 = $urandom_range(4, hc - 1);
            hist_v[hc2-4] = 1'b0; hist_h[hc2] = 1'b1;
            hist_v[hc-4] = 1'b1; hist_h[hc] = 1'b1;
            if ($urandom_range(0, 1) == 1) for (int c = hc - 4; c < 64; c++) hist_d[c] = 1'b1;
            drive_to(hc, 1'($urandom_range(0, 1)));
            build_expect(hc, guesslen);
            recv("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/md5_hit_reporter.md
Name: md5_hit_reporter

Overview:
- Host-facing transmit end of the cracker: aligns each MD5 pipeline hit with the guess that produced it, latches that plaintext, and sends it to the host as a UART 8N1 frame.
- If the guess generator finishes and the pipeline drains with no hit, sends a "not found" frame instead.
- Sits beside the top-level cracker. It consumes the generator's guess, valid and done signals and the comparator's hit output, and drives the board TX pin.

Parameters:
- PIPE_LATENCY, 64: cycles from a guess entering the MD5 pipeline to its hit result; depth of the guess/valid/done delay line (minimum 1).
- CLKS_PER_BIT, 868: clk cycles per UART bit (100 MHz / 115200); minimum 2.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- guess  input  128  current candidate from the generator; byte k = guess[8k+7:8k].
- guess_valid  input  1  guess is a real candidate this cycle (tie high if the generator issues every cycle).
- guesslen  input  4  candidate length in bytes, 0..15; static during a run.
- gen_done  input  1  generator has issued its last guess (level).
- hit  input  1  hash comparator match for the guess issued PIPE_LATENCY cycles earlier.
- uart_tx  output  1  serial out; idles high.
- busy  output  1  a frame is being transmitted.
- found  output  1  sticky: a hit was captured.
- finished  output  1  sticky: a report frame (hit or not-found) has fully completed.

Behaviour:
- Reset values: uart_tx=1, busy=0, found=0, finished=0. Delay line cleared so valid_d=0 and done_d=0; FSMs in IDLE; baud counter 0.

Delay line:
- guess, guess_valid and gen_done shift through a PIPE_LATENCY-deep register chain every cycle.
- Outputs of the chain are guess_d, valid_d and done_d; guess_d is the guess that produced this cycle's hit.
- qhit = hit & valid_d. A hit without valid_d is ignored.

Frame sequencer states: S_IDLE, S_HDR, S_BODY, S_TERM, S_DONE.
- S_IDLE with qhit:
  - capture cap_guess <= guess_d, cap_len <= guesslen, set found=1, mode=HIT;
  - go to S_HDR next cycle.
- S_IDLE with done_d and no qhit: mode=MISS; go to S_HDR.
- qhit and done_d in the same cycle: hit wins and the MISS frame is never sent.
- S_HDR: send 0x48 ('H') for HIT or 0x4E ('N') for MISS.
  - Then go to S_BODY if HIT and cap_len>0; otherwise go to S_TERM.
- S_BODY: send cap_guess byte 0 up to byte cap_len-1, LSB byte first; then go to S_TERM.
- S_TERM: send 0x0A; then set finished=1 and go to S_DONE.
- S_DONE: terminal until reset. All later hit and done_d are ignored; uart_tx stays 1.
- While in S_HDR, S_BODY or S_TERM, hits are ignored; cap_guess never changes after capture.

Byte transmitter (sub-FSM): TX_IDLE, TX_START, TX_DATA, TX_STOP.
- Each bit lasts exactly CLKS_PER_BIT cycles.
- Start bit is 0, then 8 data bits LSB first, then stop bit 1. One byte = 10*CLKS_PER_BIT cycles.
- Back-to-back bytes within a frame: the next start bit begins the cycle after the previous stop bit ends. No inter-byte idle.
- From the capture cycle, the start bit of 'H' appears on uart_tx within 2 cycles.
- busy=1 from the first start bit through the last cycle of the 0x0A stop bit; it falls in the same cycle that finished rises.

Reset mid-frame:
- uart_tx goes to 1 immediately (asynchronously).
- All state clears; the partial frame is abandoned and not resumed.

Frame length: 10*CLKS_PER_BIT*(2+cap_len) cycles for HIT; 20*CLKS_PER_BIT cycles for MISS.

Test Plan:
(Bench uses PIPE_LATENCY=4, CLKS_PER_BIT=4.)
1. Hit capture: guess=0x...0063_6261 ("abc"), guesslen=3, valid=1 at cycle 0; hit=1 at cycle 4 with other guesses around it -> found=1; uart_tx decodes bytes 0x48,0x61,0x62,0x63,0x0A; busy high 200 cycles; then finished=1.
2. Alignment: distinct guesses every cycle; hit pulses at cycle 10 -> captured bytes equal the guess issued at cycle 6, not the ones at cycles 5 or 7.
3. Miss: no hit; gen_done rises at cycle 20 -> 0x4E,0x0A sent starting ~cycle 24; found=0; finished=1 after 80 bit-cycles.
4. Simultaneous/ignored events:
   - hit and done_d coincide -> only the HIT frame is sent;
   - a second hit during transmission, or a hit with valid_d=0 -> no effect on captured bytes.
5. guesslen=0 with hit -> frame is 0x48,0x0A only; guesslen=15 -> 17 bytes, with byte 14 = guess[119:112].
6. Reset asserted mid-body byte -> uart_tx=1 within the same cycle; busy=0, found=0, finished=0; a fresh hit afterwards produces a complete new frame.
